pbch_re_index_gen: RTL and testbench

Generates the ordered (symbol, subcarrier) resource-element indices of the PBCH inside one SSB, one index per accepted handshake. It is triggered by the post-FFT top controller's indices-valid pulse, using the latched cell ID. It feeds the PBCH RE extractor and the equalizer, which read the resource grid in this order. DMRS positions are derived from v = ncellid mod 4 per 38.211 7.4.3.1.

---
 rtl/pbch_pkg.sv | 16 +
 rtl/pbch_sc_stepper.sv | 62 ++++++
 rtl/pbch_re_index_gen.sv | 152 +++++++++++++++
 tb/tb_pbch_re_index_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pbch_pkg.sv
// Shared constants and FSM encoding for the PBCH resource-element index generator.
package pbch_pkg;
   localparam int SSB_NUM_SC     = 240;
   localparam int PBCH_SYM_FIRST = 1;
   localparam int PBCH_SYM_LAST  = 3;
   localparam int SYM2_LO_END    = 47;
   localparam int SYM2_HI_START  = 192;
   localparam int PBCH_DATA_RE   = 432;
   localparam int PBCH_DMRS_RE   = 144;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      FIN  = 2'd2
   } pbch_state_e;
endpackage

// File: rtl/pbch_sc_stepper.sv
// Combinational successor of (sym, sc) in PBCH RE order; init_i yields the first RE instead.
// DMRS REs (sc mod 4 == v) are stepped over unless dmrs_en_i is set.
module pbch_sc_stepper
   import pbch_pkg::*;
#(
   parameter int SC_W  = 8,
   parameter int SYM_W = 2
) (
   input  logic             init_i,
   input  logic [1:0]       v_i,
   input  logic             dmrs_en_i,
   input  logic [SYM_W-1:0] sym_i,
   input  logic [SC_W-1:0]  sc_i,
   output logic [SYM_W-1:0] nxt_sym_o,
   output logic [SC_W-1:0]  nxt_sc_o,
   output logic             nxt_dmrs_o,
   output logic             nxt_last_o
);
   typedef struct packed {
      logic [SYM_W-1:0] sym;
      logic [SC_W-1:0]  sc;
   } re_pos_t;

   function automatic re_pos_t advance(input re_pos_t p);
      re_pos_t n;
      n.sym = p.sym;
      n.sc  = p.sc + SC_W'(1);
      if (p.sym == SYM_W'(PBCH_SYM_FIRST + 1) && p.sc == SC_W'(SYM2_LO_END)) begin
         n.sc = SC_W'(SYM2_HI_START);
      end else if (p.sc == SC_W'(SSB_NUM_SC - 1)) begin
         n.sym = p.sym + SYM_W'(1);
         n.sc  = '0;
      end
      return n;
   endfunction

   re_pos_t          cur, cand, cand2, nxt;
   logic             skip;
   logic [SC_W-1:0]  last_sc;

   always_comb begin
      cur.sym = sym_i;
      cur.sc  = sc_i;
      if (init_i) begin
         cand.sym = SYM_W'(PBCH_SYM_FIRST);
         cand.sc  = '0;
      end else begin
         cand = advance(cur);
      end
      // DMRS pitch is 4 and both sym-2 segment edges are multiples of 4, so one skip suffices
      cand2 = advance(cand);
      skip  = !dmrs_en_i && (cand.sc[1:0] == v_i);
      nxt   = skip ? cand2 : cand;

      last_sc = (dmrs_en_i || v_i != 2'd3) ? SC_W'(SSB_NUM_SC - 1) : SC_W'(SSB_NUM_SC - 2);

      nxt_sym_o  = nxt.sym;
      nxt_sc_o   = nxt.sc;
      nxt_dmrs_o = dmrs_en_i && (nxt.sc[1:0] == v_i);
      nxt_last_o = (nxt.sym == SYM_W'(PBCH_SYM_LAST)) && (nxt.sc == last_sc);
   end
endmodule

// File: rtl/pbch_re_index_gen.sv
// PBCH RE index generator: emits the SSB's PBCH (sym, sc) indices in grid order, one per valid/ready handshake.
// Define PBCH_DMRS_IDX_EN to emit DMRS REs too (576 indices); otherwise they are skipped (432 indices).
module pbch_re_index_gen
   import pbch_pkg::*;
#(
   parameter int SC_W  = 8,
   parameter int SYM_W = 2,
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [9:0]       ncellid,
   input  logic             out_ready,
   output logic             idx_valid,
   output logic [SYM_W-1:0] idx_sym,
   output logic [SC_W-1:0]  idx_sc,
   output logic             idx_dmrs,
   output logic             idx_last,
   output logic [CNT_W-1:0] idx_count,
   output logic             busy,
   output logic             done
);
`ifdef PBCH_DMRS_IDX_EN
   localparam logic DMRS_EN = 1'b1;
`else
   localparam logic DMRS_EN = 1'b0;
`endif
   localparam int TOTAL_RE = DMRS_EN ? (PBCH_DATA_RE + PBCH_DMRS_RE) : PBCH_DATA_RE;

   if ((1 << CNT_W) <= TOTAL_RE) begin : g_cnt_w_chk
      $error("CNT_W too narrow for the PBCH RE count");
   end

   pbch_state_e      state_q, state_d;
   logic [1:0]       v_q, v_d;
   logic [SYM_W-1:0] sym_q, sym_d;
   logic [SC_W-1:0]  sc_q, sc_d;
   logic             dmrs_q, dmrs_d;
   logic             last_q, last_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             step_init;
   logic [1:0]       step_v;
   logic [SYM_W-1:0] nxt_sym;
   logic [SC_W-1:0]  nxt_sc;
   logic             nxt_dmrs, nxt_last;
   logic             unused_cid;

   assign unused_cid = ^ncellid[9:2];
   // In IDLE the stepper sees the incoming cell ID so the first RE is ready on the accepting edge
   assign step_init  = (state_q == IDLE);
   assign step_v     = step_init ? ncellid[1:0] : v_q;

   pbch_sc_stepper #(.SC_W(SC_W), .SYM_W(SYM_W)) u_stepper (
      .init_i     (step_init),
      .v_i        (step_v),
      .dmrs_en_i  (DMRS_EN),
      .sym_i      (sym_q),
      .sc_i       (sc_q),
      .nxt_sym_o  (nxt_sym),
      .nxt_sc_o   (nxt_sc),
      .nxt_dmrs_o (nxt_dmrs),
      .nxt_last_o (nxt_last)
   );

   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      sym_d   = sym_q;
      sc_d    = sc_q;
      dmrs_d  = dmrs_q;
      last_d  = last_q;
      valid_d = valid_q;
      count_d = count_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = GEN;
               v_d     = ncellid[1:0];
               count_d = '0;
               sym_d   = nxt_sym;
               sc_d    = nxt_sc;
               dmrs_d  = nxt_dmrs;
               last_d  = nxt_last;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         GEN: begin
            if (valid_q && out_ready) begin
               count_d = count_q + CNT_W'(1);
               if (last_q) begin
                  state_d = FIN;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  last_d  = 1'b0;
                  dmrs_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  sym_d  = nxt_sym;
                  sc_d   = nxt_sc;
                  dmrs_d = nxt_dmrs;
                  last_d = nxt_last;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         v_q     <= '0;
         sym_q   <= '0;
         sc_q    <= '0;
         dmrs_q  <= 1'b0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         sym_q   <= sym_d;
         sc_q    <= sc_d;
         dmrs_q  <= dmrs_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign idx_valid = valid_q;
   assign idx_sym   = sym_q;
   assign idx_sc    = sc_q;
   assign idx_dmrs  = dmrs_q;
   assign idx_last  = last_q;
   assign idx_count = count_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_pbch_re_index_gen.sv
// Bench for pbch_re_index_gen: vector table plus reference RE list built from the SSB/PBCH grid rules.
module tb_pbch_re_index_gen;
`ifdef PBCH_DMRS_IDX_EN
   localparam bit DMRS_EN = 1'b1;
`else
   localparam bit DMRS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, start, out_ready;
   logic [9:0] ncellid;
   logic       idx_valid, idx_dmrs, idx_last, busy, done;
   logic [1:0] idx_sym;
   logic [7:0] idx_sc;
   logic [9:0] idx_count;

   always #5 clk = ~clk;

   pbch_re_index_gen #(.SC_W(8), .SYM_W(2), .CNT_W(10)) dut (
      .clk(clk), .rst(rst), .start(start), .ncellid(ncellid), .out_ready(out_ready),
      .idx_valid(idx_valid), .idx_sym(idx_sym), .idx_sc(idx_sc), .idx_dmrs(idx_dmrs),
      .idx_last(idx_last), .idx_count(idx_count), .busy(busy), .done(done)
   );

   typedef struct packed {
      logic [1:0] sym;
      logic [7:0] sc;
      logic       dmrs;
   } re_t;

   typedef struct {
      int cid;
      int ord;
      int sym;
      int sc;
      int dmrs;
   } tv_t;

   re_t ref_q[$];
   re_t got_q[$];
   re_t run0_q[$];
   tv_t tv[$];
   int  n_chk = 0;
   int  n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: every RE of symbols 1..3, minus the sym-2 SSS gap, minus DMRS unless emitted
   task automatic build_ref(input int v);
      ref_q.delete();
      for (int s = 1; s <= 3; s++) begin
         for (int c = 0; c < 240; c++) begin
            bit d;
            d = ((c % 4) == v);
            if (s == 2 && c >= 48 && c < 192) continue;
            if (d && !DMRS_EN) continue;
            ref_q.push_back('{sym: 2'(s), sc: 8'(c), dmrs: d});
         end
      end
   endtask

   task automatic run_seq(input logic [9:0] cid, input bit rnd, input int mid_at, input int rst_at,
                          input bit chain, input logic [9:0] chain_cid, output bit aborted);
      logic [11:0] prev_vec, cur_vec;
      bit          stalled, fin, mid_fired;
      int          hs, cyc;
      aborted = 1'b0;
      got_q.delete();
      build_ref(int'(cid[1:0]));
      start = 1'b1; ncellid = cid; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("first_valid", idx_valid, 1);
      chk("first_busy", busy, 1);
      hs = 0; cyc = 0; stalled = 0; fin = 0; mid_fired = 0; prev_vec = '0;
      while (!fin && cyc < 3000) begin
         cur_vec = {idx_sym, idx_sc, idx_dmrs, idx_last};
         if (stalled) chk("stall_hold", cur_vec, prev_vec);
         chk("valid_in_gen", idx_valid, 1);
         chk("count_track", idx_count, hs);
         if (rst_at >= 0 && hs == rst_at) begin
            rst = 1'b1;
            #1;
            chk("rst_valid", idx_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_count", idx_count, 0);
            chk("rst_done", done, 0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("rst_no_done", done, 0);
            chk("rst_idle_valid", idx_valid, 0);
            aborted = 1'b1;
            return;
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         ncellid   = 10'($urandom);
         start     = (mid_at >= 0 && hs == mid_at && !mid_fired);
         if (start) begin
            mid_fired = 1;
            ncellid   = cid ^ 10'd2;
         end
         if (idx_valid && out_ready) begin
            if (hs < ref_q.size()) begin
               chk("re_sym", idx_sym, ref_q[hs].sym);
               chk("re_sc", idx_sc, ref_q[hs].sc);
               chk("re_dmrs", idx_dmrs, ref_q[hs].dmrs);
               chk("re_last", idx_last, hs == ref_q.size() - 1);
            end else begin
               chk("re_overrun", hs, ref_q.size() - 1);
            end
            got_q.push_back('{sym: idx_sym, sc: idx_sc, dmrs: idx_dmrs});
            hs++;
            fin = idx_last;
         end
         stalled  = idx_valid && !out_ready;
         prev_vec = cur_vec;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (!fin) begin
         chk("timeout_no_last", fin, 1);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
         return;
      end
      chk("done_pulse", done, 1);
      chk("fin_valid", idx_valid, 0);
      chk("fin_busy", busy, 0);
      chk("final_count", idx_count, ref_q.size());
      chk("total_hs", hs, ref_q.size());
      // A start raised while done is high must be ignored, and accepted on the following cycle
      start = chain; ncellid = chain_cid;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("fin_start_ignored", idx_valid, 0);
      chk("count_hold", idx_count, ref_q.size());
   endtask

   task automatic table_check(input int cid);
      foreach (tv[i]) begin
         if (tv[i].cid == cid) begin
            if (tv[i].ord < got_q.size()) begin
               chk("tv_sym", got_q[tv[i].ord].sym, tv[i].sym);
               chk("tv_sc", got_q[tv[i].ord].sc, tv[i].sc);
               chk("tv_dmrs", got_q[tv[i].ord].dmrs, tv[i].dmrs);
            end else begin
               chk("tv_missing", got_q.size(), tv[i].ord + 1);
            end
         end
      end
   endtask

   initial begin
      bit ab;
      int n2, ngap, nd, mism;
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; ncellid = '0;
`ifdef PBCH_DMRS_IDX_EN
      tv.push_back('{1, 0,   1, 0,   0});
      tv.push_back('{1, 1,   1, 1,   1});
      tv.push_back('{1, 2,   1, 2,   0});
      tv.push_back('{1, 287, 2, 47,  0});
      tv.push_back('{1, 288, 2, 192, 0});
      tv.push_back('{1, 575, 3, 239, 0});
`else
      tv.push_back('{0, 0,   1, 1,   0});
      tv.push_back('{0, 1,   1, 2,   0});
      tv.push_back('{0, 2,   1, 3,   0});
      tv.push_back('{0, 3,   1, 5,   0});
      tv.push_back('{0, 215, 2, 47,  0});
      tv.push_back('{0, 216, 2, 193, 0});
      tv.push_back('{0, 431, 3, 239, 0});
      tv.push_back('{7, 0,   1, 0,   0});
      tv.push_back('{7, 1,   1, 1,   0});
      tv.push_back('{7, 2,   1, 2,   0});
      tv.push_back('{7, 3,   1, 4,   0});
      tv.push_back('{7, 215, 2, 46,  0});
      tv.push_back('{7, 216, 2, 192, 0});
      tv.push_back('{7, 431, 3, 238, 0});
`endif
      @(negedge clk);
      chk("rst_idx_valid", idx_valid, 0);
      chk("rst_idx_sym", idx_sym, 0);
      chk("rst_idx_sc", idx_sc, 0);
      chk("rst_idx_dmrs", idx_dmrs, 0);
      chk("rst_idx_last", idx_last, 0);
      chk("rst_idx_count", idx_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_no_start", idx_valid, 0);

      run_seq(10'd0, 1'b0, -1, -1, 1'b0, 10'd0, ab);
      table_check(0);
      n2 = 0; ngap = 0; nd = 0;
      foreach (got_q[i]) begin
         if (got_q[i].sym == 2'd2) n2++;
         if (got_q[i].sym == 2'd2 && got_q[i].sc >= 8'd48 && got_q[i].sc < 8'd192) ngap++;
         if (got_q[i].dmrs) nd++;
      end
      chk("sym2_count", n2, DMRS_EN ? 96 : 72);
      chk("sym2_gap", ngap, 0);
      chk("dmrs_total", nd, DMRS_EN ? 144 : 0);
      run0_q = got_q;

      run_seq(10'd7, 1'b0, -1, -1, 1'b1, 10'd0, ab);
      table_check(7);

      run_seq(10'd0, 1'b1, -1, -1, 1'b0, 10'd0, ab);
      mism = 0;
      foreach (got_q[i]) if (i >= run0_q.size() || got_q[i] != run0_q[i]) mism++;
      chk("rnd_len", got_q.size(), run0_q.size());
      chk("rnd_seq_equal", mism, 0);

      run_seq(10'd1, 1'b1, -1, -1, 1'b0, 10'd0, ab);
      table_check(1);

      run_seq(10'd4, 1'b1, 50, 100, 1'b0, 10'd0, ab);
      chk("rst_aborted", ab, 1);
      chk("rst_partial", got_q.size(), 100);

      run_seq(10'd2, 1'b1, -1, -1, 1'b0, 10'd0, ab);
      chk("clean_after_rst", got_q.size(), DMRS_EN ? 576 : 432);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
